// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one sram-like slave port between an instruction
// master and a data master.
//
// Build option: define SRAM_ARB_ROUND_ROBIN_EN to resolve request conflicts
// round-robin. Without it, the data master wins every conflict.
//
// Handshake: a master holds req and its request fields stable until it sees
// addr_ok. addr_ok is asserted in the cycle where out_req and out_addr_ok are
// both high, and that cycle is the acceptance. Each accepted request later
// receives exactly one data_ok. Responses return in acceptance order and are
// steered back to the owning master through a small in-order ownership FIFO.
// Request and response paths are purely combinational. The only state is
// the ownership FIFO, its count, the lock, and the round-robin last-grant bit.

module sram_arbiter #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        out_req,
  output logic        out_wr,
  output logic [1:0]  out_size,
  output logic [3:0]  out_wstrb,
  output logic [31:0] out_addr,
  output logic [31:0] out_wdata,
  input  logic        out_addr_ok,
  input  logic        out_data_ok,
  input  logic [31:0] out_rdata
);

  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  // Owner IDs stored in the ownership FIFO and used for the grant.
  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  // Ownership FIFO state. Pointers wrap naturally because the depth is a
  // power of two.
  logic [MAX_OUTSTANDING-1:0] owner_fifo;
  logic [PTR_W-1:0]           rd_ptr;
  logic [PTR_W-1:0]           wr_ptr;
  logic [CNT_W-1:0]           count;

  // The lock freezes the grant while a presented request waits for
  // out_addr_ok, so the slave sees stable request fields.
  logic lock;
  logic lock_owner;

  // Combinational arbitration and handshake terms.
  logic grant;
  logic granted_req;
  logic full;
  logic empty;
  logic accept;
  logic pop;
  logic head_owner;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Master granted at the most recent acceptance.
  logic last_grant;
`endif

  assign full       = (count == CNT_W'(MAX_OUTSTANDING));
  assign empty      = (count == '0);
  assign head_owner = owner_fifo[rd_ptr];

  // Choose the granted master. A locked grant always wins. Otherwise a lone
  // requester is granted, and a conflict goes to the configured policy.
  always_comb begin
    grant = OWNER_INST;
    if (lock) begin
      grant = lock_owner;
    end else if (inst_req && data_req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      grant = ~last_grant;
`else
      grant = OWNER_DATA;
`endif
    end else if (data_req) begin
      grant = OWNER_DATA;
    end else begin
      grant = OWNER_INST;
    end
  end

  // Steer the granted master's request fields onto the shared slave port.
  always_comb begin
    granted_req = inst_req;
    out_wr      = inst_wr;
    out_size    = inst_size;
    out_wstrb   = inst_wstrb;
    out_addr    = inst_addr;
    out_wdata   = inst_wdata;
    if (grant == OWNER_DATA) begin
      granted_req = data_req;
      out_wr      = data_wr;
      out_size    = data_size;
      out_wstrb   = data_wstrb;
      out_addr    = data_addr;
      out_wdata   = data_wdata;
    end
  end

  // Gate the request and the handshakes. Nothing is issued during reset,
  // no request is issued while the FIFO is full, and out_data_ok is
  // ignored while no response is owed.
  always_comb begin
    out_req      = !reset && granted_req && !full;
    accept       = out_req && out_addr_ok;
    pop          = !reset && out_data_ok && !empty;
    inst_addr_ok = accept && (grant == OWNER_INST);
    data_addr_ok = accept && (grant == OWNER_DATA);
    inst_data_ok = pop && (head_owner == OWNER_INST);
    data_data_ok = pop && (head_owner == OWNER_DATA);
  end

  // Read data is shared; only data_ok identifies the owner.
  assign inst_rdata = out_rdata;
  assign data_rdata = out_rdata;

  // Ownership FIFO: push the owner on acceptance and pop on a response.
  // A push and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_fifo <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      if (accept) begin
        owner_fifo[wr_ptr] <= grant;
        wr_ptr             <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Lock while a presented request waits for out_addr_ok, and release on
  // acceptance. out_req is low when full, so the lock never sets then.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock       <= 1'b0;
      lock_owner <= OWNER_INST;
    end else begin
      lock <= out_req && !out_addr_ok;
      if (out_req && !out_addr_ok) begin
        lock_owner <= grant;
      end
    end
  end

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  // Track the master granted at the last acceptance for round-robin.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= OWNER_INST;
    end else if (accept) begin
      last_grant <= grant;
    end
  end
`endif

endmodule
